// File: rtl/rfid_pkg.sv
// Shared definitions for the RFID tag manager.
// FSM state encoding, fill bits of the two reserved UID values,
// and the slot-index width helper.
package rfid_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_EVAL,
    S_LOOKUP,
    S_LEARN,
    S_REPORT,
    S_WAIT_POLL
  } state_e;

  // Reserved UIDs are all-zeros and all-ones; stored as fill bits so any UID_W works
  localparam logic UID_INVALID_LO = 1'b0;
  localparam logic UID_INVALID_HI = 1'b1;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rfid_tag_manager_if.sv
// Reader handshake between the tag manager and rc522_controller.
//   reader_start : one-cycle start pulse (manager -> controller)
//   reader_uid   : UID, valid with reader_done (controller -> manager)
//   reader_done  : completion strobe (controller -> manager)
interface rfid_tag_manager_if #(
  parameter int unsigned UID_W = 32
) ();

  logic             reader_start;
  logic [UID_W-1:0] reader_uid;
  logic             reader_done;

  modport master (output reader_start, input reader_uid, input reader_done);
  modport slave  (input reader_start, output reader_uid, output reader_done);

endinterface

// File: rtl/rfid_uid_table.sv
// Registration table of known tag UIDs.
//   clk, rst          : clock, async active-low clear of valid bits
//   i_rd_idx          : scan address -> o_rd_uid_c / o_rd_valid_c
//   i_we/i_wr_idx/uid : enrolment write, sets the slot's valid bit
//   o_first_free_c    : lowest invalid slot, o_full_c when none
module rfid_uid_table
  import rfid_pkg::*;
#(
  parameter int unsigned UID_W    = 32,
  parameter int unsigned NUM_TAGS = 4,
  localparam int unsigned IDX_W   = idx_w(NUM_TAGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [UID_W-1:0] o_rd_uid_c,
  output logic             o_rd_valid_c,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [UID_W-1:0] i_wr_uid,
  output logic [IDX_W-1:0] o_first_free_c,
  output logic             o_full_c
);

  logic [UID_W-1:0]    r_mem [NUM_TAGS];
  logic [NUM_TAGS-1:0] r_valid;

  // Only valid bits are cleared; stale data behind an invalid slot is never matched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_valid <= '0;
    else if (i_we) r_valid[i_wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_idx] <= i_wr_uid;
  end

  assign o_rd_uid_c   = r_mem[i_rd_idx];
  assign o_rd_valid_c = r_valid[i_rd_idx];

  // Priority encoder: descending scan so the lowest free slot wins
  always_comb begin
    o_first_free_c = '0;
    o_full_c       = 1'b1;
    for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        o_first_free_c = IDX_W'(i);
        o_full_c       = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rfid_tag_manager.sv
// Polls the RC522 controller, confirms UIDs over consecutive reads, matches
// them against the registration table, optionally enrolls, and reports
// tag arrival/removal to the game logic.
//   clk, rst       : clock, async active-low reset
//   enable, learn  : polling enable, enrolment request (sampled in LOOKUP)
//   rdr            : reader handshake (master side)
//   tag_*          : confirmed tag status and event pulses
//   learn_done/full: enrolment result pulses, busy: FSM is active
module rfid_tag_manager
  import rfid_pkg::*;
#(
  parameter int unsigned UID_W          = 32,
  parameter int unsigned NUM_TAGS       = 4,
  parameter int unsigned POLL_CYCLES    = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned CONFIRM_READS  = 2,
  localparam int unsigned IDX_W         = idx_w(NUM_TAGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                learn,
  rfid_tag_manager_if.master  rdr,
  output logic                tag_present,
  output logic                tag_known,
  output logic [IDX_W-1:0]    tag_index,
  output logic [UID_W-1:0]    tag_uid,
  output logic                tag_event,
  output logic                tag_removed,
  output logic                learn_done,
  output logic                learn_full,
  output logic                busy
);

  localparam int unsigned CNT_MAX = (POLL_CYCLES > TIMEOUT_CYCLES) ? POLL_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned CONF_W  = $clog2(CONFIRM_READS + 1);

  state_e r_state, w_state_nxt;

  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_got_done, w_got_done_nxt;
  logic [UID_W-1:0]  r_uid_cap, w_uid_cap_nxt;
  logic [UID_W-1:0]  r_cand, w_cand_nxt;
  logic [CONF_W-1:0] r_conf, w_conf_nxt;
  logic [IDX_W-1:0]  r_scan, w_scan_nxt;
  logic              r_start, w_start_nxt;
  logic              r_present, w_present_nxt;
  logic              r_known, w_known_nxt;
  logic [IDX_W-1:0]  r_index, w_index_nxt;
  logic [UID_W-1:0]  r_tag_uid, w_tag_uid_nxt;
  logic              r_event, w_event_nxt;
  logic              r_removed, w_removed_nxt;
  logic              r_ldone, w_ldone_nxt;
  logic              r_lfull, w_lfull_nxt;
  logic              r_busy, w_busy_nxt;

  logic [UID_W-1:0]  w_tbl_uid;
  logic              w_tbl_valid, w_tbl_full, w_tbl_we;
  logic [IDX_W-1:0]  w_tbl_free;

  logic              w_valid, w_same, w_hit, w_scan_last, w_tmo, w_poll_end, w_present_eval;
  logic [CONF_W-1:0] w_conf_eval;

  rfid_uid_table #(.UID_W(UID_W), .NUM_TAGS(NUM_TAGS)) u_table (
    .clk            (clk),
    .rst            (rst),
    .i_rd_idx       (r_scan),
    .o_rd_uid_c     (w_tbl_uid),
    .o_rd_valid_c   (w_tbl_valid),
    .i_we           (w_tbl_we),
    .i_wr_idx       (w_tbl_free),
    .i_wr_uid       (r_cand),
    .o_first_free_c (w_tbl_free),
    .o_full_c       (w_tbl_full)
  );

  // Read qualification and confirm-count update used by EVAL
  assign w_valid     = r_got_done && (r_uid_cap != {UID_W{UID_INVALID_LO}})
                                  && (r_uid_cap != {UID_W{UID_INVALID_HI}});
  assign w_same      = (r_uid_cap == r_cand);
  assign w_conf_eval = !w_valid ? '0 :
                       !w_same  ? CONF_W'(1) :
                       (r_conf == CONF_W'(CONFIRM_READS)) ? r_conf : r_conf + CONF_W'(1);
  // A present tag survives EVAL only if the same UID was read again
  assign w_present_eval = r_present && w_valid && w_same;
  assign w_hit       = w_tbl_valid && (w_tbl_uid == r_cand);
  assign w_scan_last = (r_scan == IDX_W'(NUM_TAGS - 1));
  assign w_tmo       = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_poll_end  = (r_cnt == CNT_W'(POLL_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (enable) w_state_nxt = S_START;
      S_START:     w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (rdr.reader_done || w_tmo) w_state_nxt = S_EVAL;
      S_EVAL:      w_state_nxt = (w_valid && (w_conf_eval == CONF_W'(CONFIRM_READS)) && !w_present_eval)
                                 ? S_LOOKUP : S_WAIT_POLL;
      S_LOOKUP:    if (w_hit)            w_state_nxt = S_REPORT;
                   else if (w_scan_last) w_state_nxt = learn ? S_LEARN : S_REPORT;
      S_LEARN:     w_state_nxt = S_REPORT;
      S_REPORT:    w_state_nxt = S_WAIT_POLL;
      S_WAIT_POLL: if (!enable)          w_state_nxt = S_IDLE;
                   else if (w_poll_end)  w_state_nxt = S_START;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values; Moore-style outputs use look-ahead on w_state_nxt
  always_comb begin
    w_got_done_nxt = r_got_done;
    w_uid_cap_nxt  = r_uid_cap;
    w_cand_nxt     = r_cand;
    w_conf_nxt     = r_conf;
    w_scan_nxt     = r_scan;
    w_present_nxt  = r_present;
    w_known_nxt    = r_known;
    w_index_nxt    = r_index;
    w_tag_uid_nxt  = r_tag_uid;
    w_event_nxt    = 1'b0;
    w_removed_nxt  = 1'b0;
    w_ldone_nxt    = 1'b0;
    w_lfull_nxt    = 1'b0;
    w_tbl_we       = 1'b0;
    w_start_nxt    = (w_state_nxt == S_START);
    w_busy_nxt     = !(w_state_nxt inside {S_IDLE, S_WAIT_POLL});
    w_cnt_nxt      = ((w_state_nxt == r_state) && (r_state inside {S_WAIT_DONE, S_WAIT_POLL}))
                     ? r_cnt + CNT_W'(1) : '0;

    case (r_state)
      S_START: w_got_done_nxt = 1'b0;
      S_WAIT_DONE: begin
        if (rdr.reader_done) begin
          w_got_done_nxt = 1'b1;
          w_uid_cap_nxt  = rdr.reader_uid;
        end
      end
      S_EVAL: begin
        w_conf_nxt = w_conf_eval;
        w_scan_nxt = '0;
        if (w_valid && !w_same) w_cand_nxt = r_uid_cap;
        if (r_present && !w_present_eval) begin
          w_removed_nxt = 1'b1;
          w_present_nxt = 1'b0;
          w_known_nxt   = 1'b0;
        end
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_known_nxt = 1'b1;
          w_index_nxt = r_scan;
        end else if (w_scan_last) begin
          if (!learn) begin
            w_known_nxt = 1'b0;
            w_index_nxt = '0;
          end
        end else begin
          w_scan_nxt = r_scan + IDX_W'(1);
        end
      end
      S_LEARN: begin
        if (!w_tbl_full) begin
          w_tbl_we    = 1'b1;
          w_ldone_nxt = 1'b1;
          w_known_nxt = 1'b1;
          w_index_nxt = w_tbl_free;
        end else begin
          w_lfull_nxt = 1'b1;
          w_known_nxt = 1'b0;
          w_index_nxt = '0;
        end
      end
      default: ;
    endcase

    if (w_state_nxt == S_REPORT) begin
      w_present_nxt = 1'b1;
      w_tag_uid_nxt = r_cand;
      w_event_nxt   = 1'b1;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_got_done <= 1'b0;
      r_uid_cap  <= '0;
      r_cand     <= '0;
      r_conf     <= '0;
      r_scan     <= '0;
      r_start    <= 1'b0;
      r_present  <= 1'b0;
      r_known    <= 1'b0;
      r_index    <= '0;
      r_tag_uid  <= '0;
      r_event    <= 1'b0;
      r_removed  <= 1'b0;
      r_ldone    <= 1'b0;
      r_lfull    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_got_done <= w_got_done_nxt;
      r_uid_cap  <= w_uid_cap_nxt;
      r_cand     <= w_cand_nxt;
      r_conf     <= w_conf_nxt;
      r_scan     <= w_scan_nxt;
      r_start    <= w_start_nxt;
      r_present  <= w_present_nxt;
      r_known    <= w_known_nxt;
      r_index    <= w_index_nxt;
      r_tag_uid  <= w_tag_uid_nxt;
      r_event    <= w_event_nxt;
      r_removed  <= w_removed_nxt;
      r_ldone    <= w_ldone_nxt;
      r_lfull    <= w_lfull_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign rdr.reader_start = r_start;
  assign tag_present      = r_present;
  assign tag_known        = r_known;
  assign tag_index        = r_index;
  assign tag_uid          = r_tag_uid;
  assign tag_event        = r_event;
  assign tag_removed      = r_removed;
  assign learn_done       = r_ldone;
  assign learn_full       = r_lfull;
  assign busy             = r_busy;

endmodule

// File: tb/tb_rfid_tag_manager.sv
// Directed bench for rfid_tag_manager with short poll/timeout periods.
module tb_rfid_tag_manager;
  import rfid_pkg::*;

  localparam int unsigned UID_W  = 32;
  localparam int unsigned PERIOD = 1 + 50 + 1 + 100;  // START + timeout + EVAL + poll

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic learn = 1'b0;
  logic tag_present, tag_known, tag_event, tag_removed, learn_done, learn_full, busy;
  logic [1:0] tag_index;
  logic [UID_W-1:0] tag_uid;

  rfid_tag_manager_if #(.UID_W(UID_W)) bus ();

  rfid_tag_manager #(
    .UID_W(UID_W), .NUM_TAGS(4), .POLL_CYCLES(100),
    .TIMEOUT_CYCLES(50), .CONFIRM_READS(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .learn(learn), .rdr(bus),
    .tag_present(tag_present), .tag_known(tag_known), .tag_index(tag_index),
    .tag_uid(tag_uid), .tag_event(tag_event), .tag_removed(tag_removed),
    .learn_done(learn_done), .learn_full(learn_full), .busy(busy)
  );

  always #5 clk = ~clk;

  wire [40:0] all_outs = {tag_present, tag_known, tag_index, tag_uid, tag_event,
                          tag_removed, learn_done, learn_full, busy, bus.reader_start};

  int n_cmp = 0;
  int n_fail = 0;

  // Event monitor: pulse counters, snapshot at tag_event, start spacing, pulse-width check
  int cyc = 0, ev_cnt = 0, rm_cnt = 0, ld_cnt = 0, lf_cnt = 0, st_cnt = 0, viol = 0;
  int last_st = 0, prev_st = 0;
  logic ev_known = 0, ev_present = 0, ev_ld = 0, ev_lf = 0;
  logic [1:0] ev_index = 0;
  logic [UID_W-1:0] ev_uid = 0;
  logic [4:0] prev_vec = 0;
  wire  [4:0] pulse_vec = {bus.reader_start, tag_event, tag_removed, learn_done, learn_full};

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tag_event) begin
      ev_cnt <= ev_cnt + 1;
      ev_known <= tag_known;  ev_index <= tag_index;  ev_uid <= tag_uid;
      ev_present <= tag_present;  ev_ld <= learn_done;  ev_lf <= learn_full;
    end
    if (tag_removed) rm_cnt <= rm_cnt + 1;
    if (learn_done)  ld_cnt <= ld_cnt + 1;
    if (learn_full)  lf_cnt <= lf_cnt + 1;
    if (bus.reader_start) begin
      st_cnt <= st_cnt + 1;
      prev_st <= last_st;
      last_st <= cyc;
    end
    if ((pulse_vec & prev_vec) != 5'd0) viol <= viol + 1;
    prev_vec <= pulse_vec;
  end

  task automatic wait_start();
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (bus.reader_start) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL start_wait: reader_start not seen within 400 cycles");
    end
  endtask

  // One read attempt: answer with uid after 3 cycles, or let it time out
  task automatic do_read(input logic [UID_W-1:0] uid, input bit give);
    wait_start();
    if (give) begin
      repeat (3) @(negedge clk);
      bus.reader_uid = uid;
      bus.reader_done = 1'b1;
      @(negedge clk);
      bus.reader_done = 1'b0;
      repeat (10) @(negedge clk);
    end else begin
      repeat (60) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.reader_uid = '0;
    bus.reader_done = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (all_outs !== 41'd0) begin n_fail++; $display("FAIL reset_outs: got %h want 0", all_outs); end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({busy, st_cnt} !== {1'b0, 32'd0}) begin
      n_fail++; $display("FAIL idle_disabled: busy=%b starts=%0d want 0/0", busy, st_cnt);
    end
  endtask

  task automatic test_poll_timeout();
    int ev0;
    ev0 = ev_cnt;
    enable = 1'b1;
    wait_start();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_wait_done: got %b want 1", busy); end
    repeat (55) @(negedge clk);
    n_cmp++;
    if (all_outs !== 41'd0) begin n_fail++; $display("FAIL poll_outs: got %h want 0", all_outs); end
    do_read('0, 1'b0);
    do_read('0, 1'b0);
    n_cmp++;
    if (last_st - prev_st !== PERIOD) begin
      n_fail++; $display("FAIL poll_period: got %0d want %0d", last_st - prev_st, PERIOD);
    end
    n_cmp++;
    if (ev_cnt - ev0 !== 0) begin n_fail++; $display("FAIL poll_no_event: got %0d want 0", ev_cnt - ev0); end
  endtask

  task automatic test_learn_enroll();
    int ev0;
    learn = 1'b1;
    ev0 = ev_cnt;
    do_read(32'h3C3C3C3C, 1'b1);
    n_cmp++;
    if (ev_cnt - ev0 !== 0) begin n_fail++; $display("FAIL enroll_first_read: events=%0d want 0", ev_cnt - ev0); end
    do_read(32'h3C3C3C3C, 1'b1);
    n_cmp++;
    if (ev_cnt - ev0 !== 1) begin n_fail++; $display("FAIL enroll_event: events=%0d want 1", ev_cnt - ev0); end
    n_cmp++;
    if ({ev_ld, ev_lf, ev_known, ev_index, ev_present} !== 6'b101001) begin
      n_fail++; $display("FAIL enroll_flags: ld/lf/known/idx/present=%b want 101001",
                         {ev_ld, ev_lf, ev_known, ev_index, ev_present});
    end
    n_cmp++;
    if (ev_uid !== 32'h3C3C3C3C) begin n_fail++; $display("FAIL enroll_uid: got %h want 3c3c3c3c", ev_uid); end
  endtask

  task automatic test_same_then_removed();
    int ev0, rm0, ld0;
    ev0 = ev_cnt; rm0 = rm_cnt; ld0 = ld_cnt;
    do_read(32'h3C3C3C3C, 1'b1);
    n_cmp++;
    if ({ev_cnt - ev0, rm_cnt - rm0, ld_cnt - ld0} !== 96'd0) begin
      n_fail++; $display("FAIL same_tag_quiet: ev/rm/ld=%0d/%0d/%0d want 0/0/0",
                         ev_cnt - ev0, rm_cnt - rm0, ld_cnt - ld0);
    end
    n_cmp++;
    if (tag_present !== 1'b1) begin n_fail++; $display("FAIL same_tag_present: got %b want 1", tag_present); end
    do_read('0, 1'b0);
    n_cmp++;
    if ({rm_cnt - rm0, tag_present} !== {32'd1, 1'b0}) begin
      n_fail++; $display("FAIL removed: removals=%0d present=%b want 1/0", rm_cnt - rm0, tag_present);
    end
  endtask

  task automatic present_tag(input logic [UID_W-1:0] uid);
    do_read(uid, 1'b1);
    do_read(uid, 1'b1);
  endtask

  task automatic test_table_full();
    int ev0, lf0;
    present_tag(32'h11111111);
    n_cmp++;
    if ({ev_ld, ev_index} !== 3'b101) begin n_fail++; $display("FAIL enroll_slot1: ld/idx=%b want 101", {ev_ld, ev_index}); end
    present_tag(32'h22222222);
    n_cmp++;
    if ({ev_ld, ev_index} !== 3'b110) begin n_fail++; $display("FAIL enroll_slot2: ld/idx=%b want 110", {ev_ld, ev_index}); end
    present_tag(32'h33333333);
    n_cmp++;
    if ({ev_ld, ev_index} !== 3'b111) begin n_fail++; $display("FAIL enroll_slot3: ld/idx=%b want 111", {ev_ld, ev_index}); end
    ev0 = ev_cnt; lf0 = lf_cnt;
    present_tag(32'h44444444);
    n_cmp++;
    if ({ev_cnt - ev0, lf_cnt - lf0} !== {32'd1, 32'd1}) begin
      n_fail++; $display("FAIL full_pulses: events=%0d learn_full=%0d want 1/1", ev_cnt - ev0, lf_cnt - lf0);
    end
    n_cmp++;
    if ({ev_lf, ev_ld, ev_known, ev_present} !== 4'b1001) begin
      n_fail++; $display("FAIL full_flags: lf/ld/known/present=%b want 1001", {ev_lf, ev_ld, ev_known, ev_present});
    end
    present_tag(32'h11111111);
    n_cmp++;
    if ({ev_ld, ev_known, ev_index, ev_uid} !== {1'b0, 1'b1, 2'd1, 32'h11111111}) begin
      n_fail++; $display("FAIL rematch_slot1: ld=%b known=%b idx=%0d uid=%h want 0/1/1/11111111",
                         ev_ld, ev_known, ev_index, ev_uid);
    end
  endtask

  task automatic test_invalid_uid();
    int ev0, rm0;
    ev0 = ev_cnt; rm0 = rm_cnt;
    do_read(32'hFFFFFFFF, 1'b1);
    n_cmp++;
    if ({ev_cnt - ev0, rm_cnt - rm0, tag_present} !== {32'd0, 32'd1, 1'b0}) begin
      n_fail++; $display("FAIL ones_is_miss: ev=%0d rm=%0d present=%b want 0/1/0", ev_cnt - ev0, rm_cnt - rm0, tag_present);
    end
    do_read(32'h00000000, 1'b1);
    do_read(32'h11111111, 1'b1);
    n_cmp++;
    if (ev_cnt - ev0 !== 0) begin n_fail++; $display("FAIL confirm_cleared: events=%0d want 0", ev_cnt - ev0); end
    do_read(32'h11111111, 1'b1);
    n_cmp++;
    if ({ev_cnt - ev0, ev_known, ev_index} !== {32'd1, 1'b1, 2'd1}) begin
      n_fail++; $display("FAIL reconfirm: ev=%0d known=%b idx=%0d want 1/1/1", ev_cnt - ev0, ev_known, ev_index);
    end
  endtask

  task automatic test_reset_mid_read();
    int ev0, rm0, ld0;
    learn = 1'b0;
    wait_start();
    repeat (3) @(negedge clk);
    ev0 = ev_cnt; rm0 = rm_cnt;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (all_outs !== 41'd0) begin n_fail++; $display("FAIL reset_mid_read: got %h want 0", all_outs); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ev_cnt - ev0, rm_cnt - rm0} !== 64'd0) begin
      n_fail++; $display("FAIL reset_no_pulse: ev=%0d rm=%0d want 0/0", ev_cnt - ev0, rm_cnt - rm0);
    end
    ev0 = ev_cnt; ld0 = ld_cnt;
    present_tag(32'h3C3C3C3C);
    n_cmp++;
    if ({ev_cnt - ev0, ld_cnt - ld0, ev_known, ev_index} !== {32'd1, 32'd0, 1'b0, 2'd0}) begin
      n_fail++; $display("FAIL table_emptied: ev=%0d ld=%0d known=%b idx=%0d want 1/0/0/0",
                         ev_cnt - ev0, ld_cnt - ld0, ev_known, ev_index);
    end
  endtask

  task automatic test_pulse_width();
    n_cmp++;
    if (viol !== 0) begin n_fail++; $display("FAIL pulse_width: %0d multi-cycle pulses want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_poll_timeout();
    test_learn_enroll();
    test_same_then_removed();
    test_table_full();
    test_invalid_uid();
    test_reset_mid_read();
    test_pulse_width();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
